// File: rtl/mm_pkg.sv
// Shared types and width helpers for the matrix-multiplier datapath.
package mm_pkg;

    typedef enum logic {
        ACC  = 1'b0,
        FULL = 1'b1
    } acc_state_t;

    // K signed products of 2N bits need $clog2(K) growth bits to be overflow-free.
    function automatic int acc_width(input int n, input int k);
        return 2 * n + $clog2(k);
    endfunction

    function automatic int cnt_width(input int k);
        return (k > 1) ? $clog2(k) : 1;
    endfunction

endpackage

// File: rtl/q_sat.sv
// Scales a signed ACC_W-bit sum by >>>B (floor) and saturates it into N signed bits.
module q_sat #(
    parameter int N     = 4,
    parameter int B     = 0,
    parameter int ACC_W = 10
) (
    input  logic [ACC_W-1:0] sum,
    output logic [N-1:0]     q,
    output logic             sat
);

    localparam logic signed [ACC_W-1:0] QMAX = ACC_W'((2 ** (N - 1)) - 1);
    localparam logic signed [ACC_W-1:0] QMIN = ACC_W'(-(2 ** (N - 1)));

    logic signed [ACC_W-1:0] sum_s;
    logic signed [ACC_W-1:0] scaled;

    assign sum_s  = sum;
    assign scaled = sum_s >>> B;

    always_comb begin
        q   = scaled[N-1:0];
        sat = 1'b0;
        if (scaled > QMAX) begin
            q   = QMAX[N-1:0];
            sat = 1'b1;
        end else if (scaled < QMIN) begin
            q   = QMIN[N-1:0];
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/dot_accumulator.sv
// Sums each group of K signed products into one dot-product term and holds it
// behind a valid/ready output register, full-width and as a scaled saturated value.
module dot_accumulator
    import mm_pkg::*;
#(
    parameter int  N     = 4,
    parameter int  B     = 0,
    parameter int  K     = 4,
    localparam int ACC_W = acc_width(N, K)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*N-1:0]   in_prod,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [N-1:0]     out_q,
    output logic             out_sat
);

    localparam int               CNT_W    = cnt_width(K);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(K - 1);

    acc_state_t              state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic        [CNT_W-1:0] cnt_q, cnt_d;
    logic        [ACC_W-1:0] out_acc_q;
    logic        [N-1:0]     out_q_q;
    logic                    out_sat_q;

    logic signed [2*N-1:0]   prod_s;
    logic signed [ACC_W-1:0] sum_d;
    logic        [N-1:0]     q_d;
    logic                    sat_d;
    logic                    in_xfer;
    logic                    last_xfer;

    assign prod_s = in_prod;
    assign sum_d  = acc_q + ACC_W'(prod_s);

    // Ready is forced low during reset and clr so that no product is silently dropped.
    assign in_ready  = rst_n && !clr && ((state_q == ACC) || out_ready);
    assign in_xfer   = in_valid && in_ready;
    assign last_xfer = in_xfer && (cnt_q == CNT_LAST);

    q_sat #(
        .N     (N),
        .B     (B),
        .ACC_W (ACC_W)
    ) u_q_sat (
        .sum (sum_d),
        .q   (q_d),
        .sat (sat_d)
    );

    always_comb begin
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        state_d = state_q;

        if (clr) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (in_xfer) begin
            if (cnt_q == CNT_LAST) begin
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = sum_d;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // A last product arriving while the old result drains reloads with no bubble.
        if (last_xfer) begin
            state_d = FULL;
        end else if ((state_q == FULL) && out_ready) begin
            state_d = ACC;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ACC;
            acc_q     <= '0;
            cnt_q     <= '0;
            out_acc_q <= '0;
            out_q_q   <= '0;
            out_sat_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            if (last_xfer) begin
                out_acc_q <= sum_d;
                out_q_q   <= q_d;
                out_sat_q <= sat_d;
            end
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_acc   = out_acc_q;
    assign out_q     = out_q_q;
    assign out_sat   = out_sat_q;

endmodule
